// File: rtl/uart_rx_ctrl.sv
// Frame-sequencing FSM for the UART receiver: walks START/DATA/PARITY/STOP
// against the external edge/bit counter and strobes the samplers and checkers.
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] prescale,
    input  logic [4:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       edge_cnt_en,
    output logic       cnt_clr,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [5:0] mid, samp_lo, samp_hi, chk, last, edge6;
    logic       at_samp, at_chk, bit_end, last_data_bit;
    logic       en_c, clr_c, samp_c, deser_c, strt_c, par_c, stp_c;
    logic       dv_nxt, fe_nxt;

    assign mid           = prescale >> 1;
    assign samp_lo       = mid - 6'd1;
    assign samp_hi       = mid + 6'd1;
    assign chk           = mid + 6'd2;
    assign last          = prescale - 6'd1;
    assign edge6         = {1'b0, edge_cnt};
    assign at_samp       = (edge6 == samp_lo) || (edge6 == mid) || (edge6 == samp_hi);
    assign at_chk        = (edge6 == chk);
    assign bit_end       = en_c && (edge6 == last);
    assign last_data_bit = (bit_cnt == 4'(DATA_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            data_valid <= dv_nxt;
            frame_err  <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        en_c      = 1'b0;
        clr_c     = 1'b0;
        samp_c    = 1'b0;
        deser_c   = 1'b0;
        strt_c    = 1'b0;
        par_c     = 1'b0;
        stp_c     = 1'b0;
        dv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // Counters sit cleared while idle; the detect cycle itself is edge 0.
                clr_c = rx_in;
                en_c  = ~rx_in;
                if (!rx_in)
                    state_nxt = START;
            end
            START: begin
                en_c   = 1'b1;
                samp_c = at_samp;
                strt_c = at_chk;
                if (bit_end)
                    state_nxt = strt_glitch ? IDLE : DATA;
            end
            DATA: begin
                en_c    = 1'b1;
                samp_c  = at_samp;
                deser_c = at_chk;
                if (bit_end && last_data_bit)
                    state_nxt = par_en ? PARITY : STOP;
            end
            PARITY: begin
                en_c   = 1'b1;
                samp_c = at_samp;
                par_c  = at_chk;
                if (bit_end) begin
                    state_nxt = par_err ? IDLE : STOP;
                    fe_nxt    = par_err;
                end
            end
            STOP: begin
                en_c   = 1'b1;
                samp_c = at_samp;
                stp_c  = at_chk;
                if (bit_end) begin
                    state_nxt = IDLE;
                    dv_nxt    = ~stp_err;
                    fe_nxt    = stp_err;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational strobes are gated by reset so nothing moves while rst is low.
    assign edge_cnt_en = rst & en_c;
    assign cnt_clr     = rst & clr_c;
    assign dat_samp_en = rst & samp_c;
    assign deser_en    = rst & deser_c;
    assign strt_chk_en = rst & strt_c;
    assign par_chk_en  = rst & par_c;
    assign stp_chk_en  = rst & stp_c;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural counter, sampler,
// deserialiser and checker model closing the loop around the FSM.
module tb_uart_rx_ctrl;

    localparam int DATA_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [4:0] edge_cnt = '0;
    logic [3:0] bit_cnt = '0;
    logic       strt_glitch, par_err, stp_err;
    logic       edge_cnt_en, cnt_clr, dat_samp_en, deser_en;
    logic       strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err;

    logic [2:0] samples = 3'b111;
    logic       sampled_bit;
    logic [7:0] shreg = '0;
    logic       glitch_q = 1'b0, par_err_q = 1'b0, stp_err_q = 1'b0;
    logic       force_par_err = 1'b0;
    logic [3:0] frame_last;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int detect_cyc = 0;
    int dv_cnt, fe_cnt, deser_cnt, deser_bad_edge, par_chk_cnt, clr_cnt;
    int dv_rel, fe_rel, first_clr_rel, dv_first_abs, dv_last_abs, clr_at_dv2;
    logic [7:0] dv_first_data, dv_last_data;

    uart_rx_ctrl #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .prescale(prescale),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .strt_glitch(strt_glitch),
        .par_err(par_err), .stp_err(stp_err), .edge_cnt_en(edge_cnt_en),
        .cnt_clr(cnt_clr), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
        .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
        .data_valid(data_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign sampled_bit = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
    assign strt_glitch = glitch_q;
    assign par_err     = par_err_q | force_par_err;
    assign stp_err     = stp_err_q;
    // Bit counter rolls back to 0 after the last bit of a frame so back-to-back frames restart cleanly.
    assign frame_last  = 4'(DATA_W + 1) + {3'b000, par_en};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt_en) begin
            if ({1'b0, edge_cnt} == prescale - 6'd1) begin
                edge_cnt <= '0;
                bit_cnt  <= (bit_cnt == frame_last) ? 4'd0 : bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end
        end
        if (dat_samp_en) samples   <= {samples[1:0], rx_in};
        if (deser_en)    shreg     <= {sampled_bit, shreg[7:1]};
        if (strt_chk_en) glitch_q  <= sampled_bit;
        if (par_chk_en)  par_err_q <= (sampled_bit != ^shreg);
        if (stp_chk_en)  stp_err_q <= ~sampled_bit;
    end

    always @(negedge clk) begin
        if (cnt_clr) begin
            if (first_clr_rel < 0) first_clr_rel = cyc - detect_cyc;
        end
        if (data_valid) begin
            if (dv_cnt == 0) begin
                dv_first_abs  = cyc;
                dv_first_data = shreg;
            end
            if (dv_cnt == 1) clr_at_dv2 = clr_cnt;
            dv_cnt++;
            dv_rel       = cyc - detect_cyc;
            dv_last_abs  = cyc;
            dv_last_data = shreg;
        end
        if (cnt_clr) clr_cnt++;
        if (frame_err) begin
            fe_cnt++;
            fe_rel = cyc - detect_cyc;
        end
        if (deser_en) begin
            deser_cnt++;
            if ({1'b0, edge_cnt} != (prescale >> 1) + 6'd2) deser_bad_edge++;
        end
        if (par_chk_en) par_chk_cnt++;
    end

    task automatic clear_monitor();
        dv_cnt = 0; fe_cnt = 0; deser_cnt = 0; deser_bad_edge = 0; par_chk_cnt = 0;
        clr_cnt = 0; dv_rel = -1; fe_rel = -1; first_clr_rel = -1; clr_at_dv2 = -1;
        dv_first_abs = 0; dv_last_abs = 0; dv_first_data = '0; dv_last_data = '0;
    endtask

    task automatic idle_cycles(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame bit by bit; max_cycles >= 0 abandons it part-way.
    task automatic drive_frame(input logic [7:0] data, input bit with_par, input int p, input int max_cycles);
        logic [10:0] bits;
        int nbits, n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        if (with_par) begin
            bits[9] = ^data;
            nbits = 11;
        end else begin
            nbits = 10;
        end
        par_en = with_par;
        prescale = 6'(p);
        detect_cyc = cyc;
        n = 0;
        for (int b = 0; b < nbits; b++) begin
            rx_in = bits[b];
            for (int c = 0; c < p; c++) begin
                if (max_cycles >= 0 && n >= max_cycles) return;
                @(posedge clk);
                #1;
                n++;
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] outs;
        #2;
        outs = {edge_cnt_en, cnt_clr, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err};
        checks++;
        if (outs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", outs, 9'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (cnt_clr !== 1'b1 || edge_cnt_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got cnt_clr=%b edge_cnt_en=%b expected 1/0", cnt_clr, edge_cnt_en);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame();
        idle_cycles(2);
        clear_monitor();
        drive_frame(8'hA5, 1'b0, 8, -1);
        idle_cycles(4);
        checks++;
        if (deser_cnt !== 8 || deser_bad_edge !== 0) begin
            errors++;
            $display("[TB] FAIL basic_deser: got %0d pulses (%0d off-edge) expected 8 (0)", deser_cnt, deser_bad_edge);
        end
        checks++;
        if (dv_cnt !== 1 || dv_rel !== 80) begin
            errors++;
            $display("[TB] FAIL basic_dv: got %0d pulses at cycle %0d expected 1 at 80", dv_cnt, dv_rel);
        end
        checks++;
        if (dv_last_data !== 8'hA5 || fe_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL basic_data: got %h fe=%0d expected a5 fe=0", dv_last_data, fe_cnt);
        end
    endtask

    task automatic test_parity_frame();
        idle_cycles(2);
        clear_monitor();
        drive_frame(8'h3C, 1'b1, 16, -1);
        idle_cycles(4);
        checks++;
        if (par_chk_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL parity_chk_count: got %0d expected 1", par_chk_cnt);
        end
        checks++;
        if (dv_cnt !== 1 || dv_rel !== 176) begin
            errors++;
            $display("[TB] FAIL parity_dv: got %0d pulses at cycle %0d expected 1 at 176", dv_cnt, dv_rel);
        end
        checks++;
        if (dv_last_data !== 8'h3C || fe_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL parity_data: got %h fe=%0d expected 3c fe=0", dv_last_data, fe_cnt);
        end
    endtask

    task automatic test_parity_error();
        idle_cycles(2);
        force_par_err = 1'b1;
        clear_monitor();
        drive_frame(8'h5A, 1'b1, 8, -1);
        idle_cycles(4);
        force_par_err = 1'b0;
        checks++;
        if (fe_cnt !== 1 || fe_rel !== 80) begin
            errors++;
            $display("[TB] FAIL parerr_fe: got %0d pulses at cycle %0d expected 1 at 80", fe_cnt, fe_rel);
        end
        checks++;
        if (dv_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL parerr_no_dv: got %0d expected 0", dv_cnt);
        end
        checks++;
        if (first_clr_rel !== 80) begin
            errors++;
            $display("[TB] FAIL parerr_idle: first cnt_clr at %0d expected 80", first_clr_rel);
        end
    endtask

    task automatic test_false_start();
        idle_cycles(2);
        clear_monitor();
        drive_frame(8'h00, 1'b0, 8, 2);
        idle_cycles(14);
        checks++;
        if (first_clr_rel !== 8) begin
            errors++;
            $display("[TB] FAIL glitch_idle: first cnt_clr at %0d expected 8", first_clr_rel);
        end
        checks++;
        if (deser_cnt !== 0 || dv_cnt !== 0 || fe_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL glitch_quiet: got deser=%0d dv=%0d fe=%0d expected 0/0/0", deser_cnt, dv_cnt, fe_cnt);
        end
    endtask

    task automatic test_back_to_back();
        idle_cycles(2);
        clear_monitor();
        drive_frame(8'h96, 1'b0, 32, -1);
        drive_frame(8'h41, 1'b0, 32, -1);
        idle_cycles(4);
        checks++;
        if (dv_cnt !== 2 || (dv_last_abs - dv_first_abs) !== 320) begin
            errors++;
            $display("[TB] FAIL b2b_spacing: got %0d pulses %0d apart expected 2 320 apart", dv_cnt, dv_last_abs - dv_first_abs);
        end
        checks++;
        if (clr_at_dv2 !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_no_clr: got %0d cnt_clr cycles expected 0", clr_at_dv2);
        end
        checks++;
        if (dv_first_data !== 8'h96 || dv_last_data !== 8'h41 || fe_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL b2b_data: got %h/%h fe=%0d expected 96/41 fe=0", dv_first_data, dv_last_data, fe_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] outs;
        idle_cycles(2);
        clear_monitor();
        drive_frame(8'hC3, 1'b0, 8, 4 * 8 + 3);
        rst = 1'b0;
        #1;
        outs = {edge_cnt_en, cnt_clr, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid, frame_err};
        checks++;
        if (outs !== 9'b0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got %b expected %b", outs, 9'b0);
        end
        rx_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (cnt_clr !== 1'b1 || dv_cnt !== 0 || fe_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL midrst_idle: got cnt_clr=%b dv=%0d fe=%0d expected 1/0/0", cnt_clr, dv_cnt, fe_cnt);
        end
        idle_cycles(3);
        clear_monitor();
        drive_frame(8'hC3, 1'b0, 8, -1);
        idle_cycles(4);
        checks++;
        if (dv_cnt !== 1 || dv_rel !== 80 || dv_last_data !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL midrst_recover: got %0d pulses at %0d data %h expected 1 at 80 data c3", dv_cnt, dv_rel, dv_last_data);
        end
    endtask

    initial begin
        clear_monitor();
        test_reset();
        test_basic_frame();
        test_parity_frame();
        test_parity_error();
        test_false_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
